// File: rtl/sentinel_pkg.sv
// sentinel_pkg: shared types and constants for the sentinel sequence lock.
//   state_t       - lock FSM states
//   ST_*          - status bus codes (COLLECT ors the matched-key count into the low nibble)
//   DEFAULT_KEYS  - factory key sequence, element 0 presented first
package sentinel_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, VERIFIED, LOCKOUT} state_t;

  localparam logic [7:0] ST_IDLE     = 8'h00;
  localparam logic [7:0] ST_COLLECT  = 8'hA0;
  localparam logic [7:0] ST_VERIFIED = 8'hC1;
  localparam logic [7:0] ST_LOCKOUT  = 8'hEE;

  localparam logic [3:0][7:0] DEFAULT_KEYS = {8'hE1, 8'h3C, 8'h5A, 8'hB6};

endpackage

// File: rtl/sentinel_seq_lock_props.sv
// sentinel_seq_lock_props: assertion module attached to the lock's ports.
//   verified may only rise on the edge after the final key was strobed, and
//   locked_out and verified are mutually exclusive.
module sentinel_seq_lock_props #(
  parameter int SEQ_LEN = 4
) (
  input logic       clk,
  input logic       rst,
  input logic       key_valid,
  input logic [3:0] seq_pos,
  input logic       verified,
  input logic       locked_out
);

  a_verify_after_last: assert property (@(posedge clk) disable iff (rst)
    $rose(verified) |-> ($past(key_valid) && $past(seq_pos) == 4'(SEQ_LEN - 1)));

  a_lock_excl: assert property (@(posedge clk) disable iff (rst)
    !(verified && locked_out));

endmodule

// File: rtl/sentinel_timer.sv
// sentinel_timer: loadable down-counter with a one-cycle expire pulse.
//   clk, rst  - clock, synchronous active-high reset
//   load      - (re)start the count at CYCLES
//   expire    - high during the last counted cycle, so a consumer acting on it
//               changes state exactly CYCLES edges after the load edge
module sentinel_timer #(
  parameter int CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                 count <= '0;
    else if (load)           count <= CW'(CYCLES);
    else if (count != '0)    count <= count - 1'b1;
  end

  assign expire = (count == CW'(1));

endmodule

// File: rtl/sentinel_seq_lock.sv
// sentinel_seq_lock: multi-key sequence authenticator with failure counting,
// timed lockout and inter-key timeout.
//   clk, rst                       - clock, synchronous active-high reset
//   key_in, key_valid              - strobed candidate key
//   relock                         - leave VERIFIED
//   prog_we, prog_idx, prog_data   - runtime key write (VERIFIED only)
//   status                         - 00 idle, A<n> collecting, C1 verified, EE lockout
//   verified, locked_out           - state flags
//   fail_count, seq_pos            - consecutive failures, keys matched so far
// Optional feature: define SENTINEL_KEY_PROG_EN to make the key store writable;
// otherwise the store is the constant KEYS and prog_* are ignored.
module sentinel_seq_lock
  import sentinel_pkg::*;
#(
  parameter int KEY_W          = 8,
  parameter int SEQ_LEN        = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 32,
  parameter logic [SEQ_LEN-1:0][KEY_W-1:0] KEYS = DEFAULT_KEYS,
  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  input  logic             relock,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_idx,
  input  logic [KEY_W-1:0] prog_data,
  output logic [7:0]       status,
  output logic             verified,
  output logic             locked_out,
  output logic [3:0]       fail_count,
  output logic [3:0]       seq_pos
);

  state_t state;
  logic [SEQ_LEN-1:0][KEY_W-1:0] keys;

  logic hunting, key_hit, last, accept, fail_ev, lock_ev;
  logic to_expire, lo_expire;
  logic [3:0] fail_next;

  // ---------------- key store ----------------
`ifdef SENTINEL_KEY_PROG_EN
  always_ff @(posedge clk) begin
    if (rst)
      keys <= KEYS;
    else if (prog_we && state == VERIFIED && 32'(prog_idx) < SEQ_LEN)
      keys[prog_idx] <= prog_data;
  end
`else
  logic unused_prog;
  assign keys        = KEYS;
  assign unused_prog = ^{prog_we, prog_idx, prog_data};
`endif

  // ---------------- key evaluation ----------------
  always_comb begin
    hunting   = (state == IDLE) || (state == COLLECT);
    key_hit   = (key_in == keys[seq_pos[IDX_W-1:0]]);
    last      = (seq_pos == 4'(SEQ_LEN - 1));
    fail_next = (fail_count == 4'hF) ? 4'hF : fail_count + 4'd1;
    accept    = hunting && key_valid && key_hit && !last;
    fail_ev   = hunting && key_valid && !key_hit;
    lock_ev   = fail_ev && (fail_next == 4'(MAX_FAIL));
  end

  // Timeout restarts on every accepted non-final key (including entry to COLLECT).
  sentinel_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst(rst), .load(accept), .expire(to_expire)
  );

  sentinel_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout (
    .clk(clk), .rst(rst), .load(lock_ev), .expire(lo_expire)
  );

  // ---------------- FSM with registered outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      seq_pos    <= '0;
      fail_count <= '0;
      status     <= ST_IDLE;
      verified   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE, COLLECT: begin
          // A strobe always wins over a timeout expiring on the same cycle.
          if (key_valid && key_hit) begin
            if (last) begin
              state      <= VERIFIED;
              seq_pos    <= '0;
              fail_count <= '0;
              status     <= ST_VERIFIED;
              verified   <= 1'b1;
            end else begin
              state   <= COLLECT;
              seq_pos <= seq_pos + 4'd1;
              status  <= {ST_COLLECT[7:4], seq_pos + 4'd1};
            end
          end else if (key_valid) begin
            fail_count <= fail_next;
            seq_pos    <= '0;
            if (lock_ev) begin
              state      <= LOCKOUT;
              status     <= ST_LOCKOUT;
              locked_out <= 1'b1;
            end else begin
              state  <= IDLE;
              status <= ST_IDLE;
            end
          end else if (state == COLLECT && to_expire) begin
            state   <= IDLE;
            seq_pos <= '0;
            status  <= ST_IDLE;
          end
        end
        VERIFIED: begin
          if (relock) begin
            state    <= IDLE;
            status   <= ST_IDLE;
            verified <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (lo_expire) begin
            state      <= IDLE;
            fail_count <= '0;
            status     <= ST_IDLE;
            locked_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
